pipeline_result_sink: RTL and testbench

//  Consumer end of the fixed-latency arithmetic pipeline.
//  - Tracks which cycles carry real results through a LATENCY-deep valid-tag shift register.
//  - Captures pipe_s into a DEPTH-entry FIFO and drains it over a valid/ready port.
//  - Issues credits upstream so the FIFO can never overflow while results are in flight.

---
 rtl/pipeline_result_sink.sv | 101 ++++++++++
 tb/tb_pipeline_result_sink.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipeline_result_sink.sv
// pipeline_result_sink: tags pipeline results, buffers them in a FIFO and issues credits upstream
// Optional feature macro RESULT_SINK_STATS_EN adds result_cnt (wrapping pops) and stall_cnt (saturating stalls).
module pipeline_result_sink #(
    parameter int WIDTH   = 5,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [WIDTH-1:0]       pipe_s,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] out_count,
    output logic                   drop_err
`ifdef RESULT_SINK_STATS_EN
    ,
    output logic [15:0]            result_cnt,
    output logic [15:0]            stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] tag;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [SW-1:0]      inflight;
    logic               issue_fire;
    logic               push;
    logic               pop;

    assign issue_fire = issue_valid & issue_ready;
    assign push       = tag[LATENCY-1];
    assign out_valid  = count != '0;
    assign pop        = out_valid & out_ready;
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign out_count  = count;

    // credits: buffered plus tagged in-flight results must stay below DEPTH, registered state only
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + SW'(tag[i]);
        issue_ready = (SW'(count) + inflight) < SW'(DEPTH);
    end

    // valid-tag shift register mirrors the upstream pipeline depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag <= '0;
        end else begin
            tag[0] <= issue_fire;
            for (int k = 1; k < LATENCY; k++) tag[k] <= tag[k-1];
        end
    end

    // result storage; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pipe_s;
    end

    // pointers wrap naturally at DEPTH; occupancy kept in its own register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end

    // sticky flag for issues offered without a credit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_err <= 1'b0;
        else if (issue_valid && !issue_ready) drop_err <= 1'b1;
    end

`ifdef RESULT_SINK_STATS_EN
    // pop counter wraps, stall counter saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            result_cnt <= pop ? result_cnt + 16'd1 : result_cnt;
            stall_cnt  <= (issue_valid && !issue_ready && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
        end
    end
`endif

    full_no_push: assert property (@(posedge clk) disable iff (reset) !(push && count == CW'(DEPTH)));

endmodule

// File: tb/tb_pipeline_result_sink.sv
// tb_pipeline_result_sink: random and directed traffic against a queue-based reference model
module tb_pipeline_result_sink;
    localparam int WIDTH   = 5;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       issue_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] pipe_s = '0;
    logic       issue_ready;
    logic       out_valid;
    logic [4:0] out_data;
    logic [2:0] out_count;
    logic       drop_err;
`ifdef RESULT_SINK_STATS_EN
    logic [15:0] result_cnt;
    logic [15:0] stall_cnt;
`endif

    pipeline_result_sink #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .pipe_s(pipe_s),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_count(out_count),
        .drop_err(drop_err)
`ifdef RESULT_SINK_STATS_EN
        ,
        .result_cnt(result_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         due_q[$];
    logic [4:0] val_q[$];
    logic [4:0] fifo_q[$];
    logic       exp_drop = 1'b0;
    logic [15:0] exp_res = '0;
    logic [15:0] exp_stall = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit exp_ready();
        return (fifo_q.size() + due_q.size()) < DEPTH;
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(fifo_q.size() > 0));
        check("out_data", 32'(out_data), fifo_q.size() > 0 ? 32'(fifo_q[0]) : 32'd0);
        check("out_count", 32'(out_count), 32'(fifo_q.size()));
        check("issue_ready", 32'(issue_ready), 32'(exp_ready()));
        check("drop_err", 32'(drop_err), 32'(exp_drop));
`ifdef RESULT_SINK_STATS_EN
        check("result_cnt", 32'(result_cnt), 32'(exp_res));
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
    endtask

    // one clock: check state, drive inputs (the bench plays the upstream pipeline), advance model
    task automatic step(input bit iv, input bit ordy, input logic [4:0] v);
        bit rdy;
        @(negedge clk);
        check_outputs();
        rdy = exp_ready();
        issue_valid = iv;
        out_ready = ordy;
        pipe_s = (due_q.size() > 0 && due_q[0] == cyc) ? val_q[0] : 5'($urandom);
        @(posedge clk);
        if (ordy && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            exp_res++;
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            fifo_q.push_back(val_q.pop_front());
        end
        if (iv && rdy) begin
            due_q.push_back(cyc + LATENCY);
            val_q.push_back(v);
        end
        if (iv && !rdy) begin
            exp_drop = 1'b1;
            if (exp_stall != 16'hFFFF) exp_stall++;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        issue_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        due_q.delete();
        val_q.delete();
        fifo_q.delete();
        exp_drop = 1'b0;
        exp_res = '0;
        exp_stall = '0;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        step(0, 1, 0);
        step(1, 1, 5'd4);
        repeat (4) step(0, 1, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, 5'(i));
        step(1, 0, 5'd9);
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        repeat (2) step(0, 0, 0);
        repeat (4) step(0, 1, 0);
        for (int i = 0; i < 40; i++) step(1, i[0], 5'($urandom));
        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom));
        repeat (6) step(0, 1, 0);
        step(1, 0, 5'd7);
        step(1, 0, 5'd8);
        repeat (3) step(0, 0, 0);
        step(1, 0, 5'd10);
        step(1, 0, 5'd11);
        do_reset();
        repeat (LATENCY + 2) step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 5'(20 + i));
        repeat (3) step(1, 0, 5'd30);
        repeat (3) step(0, 0, 0);
        step(1, 1, 5'd25);
        repeat (8) step(0, 1, 0);
        step(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
